// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer controller.
package timer_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StAlarm = 2'd3
    } state_t;

    // Largest legal value of each BCD digit kind.
    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    // Width of the alarm duration counter.
    localparam int unsigned ALARM_CNT_W = 8;

    // Full mm:ss display value, most significant digit first.
    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;
    localparam bcd_time_t TIME_ONE  = '{min_tens: 4'd0, min_ones: 4'd0,
                                         sec_tens: 4'd0, sec_ones: 4'd1};

endpackage

// File: rtl/timer_ctrl_if.sv
// Button/tick inputs and display/buzzer outputs of the timer controller.
interface timer_ctrl_if;

    logic       TICK;
    logic       START_STOP;
    logic       CLEAR;
    logic       SET_MIN;
    logic       SET_SEC;
    logic [3:0] MIN_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] SEC_ONES;
    logic       RUNNING;
    logic       ALARM;

    // Upstream side: debouncers/prescaler drive pulses, display chain reads digits.
    modport master (
        output TICK, START_STOP, CLEAR, SET_MIN, SET_SEC,
        input  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, RUNNING, ALARM
    );

    // Controller side.
    modport slave (
        input  TICK, START_STOP, CLEAR, SET_MIN, SET_SEC,
        output MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, RUNNING, ALARM
    );

endinterface

// File: rtl/timer_ctrl_bcd_digit.sv
// Single BCD digit counter, 0..MAX, wrapping in both directions.
// BO/CO flag a borrow/carry out of this digit for cascading.
module bcd_digit #(
    parameter int unsigned MAX = 9
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    input  logic       INC,
    input  logic       DEC,
    output logic [3:0] Q,
    output logic       BO,
    output logic       CO
);

    localparam logic [3:0] MaxVal = 4'(MAX);

    assign BO = DEC && (Q == 4'd0);
    assign CO = INC && (Q >= MaxVal);

    // Digit register: load beats increment beats decrement; out-of-range values snap back.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            Q <= 4'd0;
        end else if (LOAD) begin
            Q <= (LOAD_VAL > MaxVal) ? 4'd0 : LOAD_VAL;
        end else if (INC) begin
            Q <= (Q >= MaxVal) ? 4'd0 : Q + 4'd1;
        end else if (DEC) begin
            Q <= (Q == 4'd0 || Q > MaxVal) ? MaxVal : Q - 4'd1;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: set / run / pause / alarm sequencing over four BCD digits.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic         CLOCK,
    input  logic         RESET,
    timer_ctrl_if.slave  bus
);

    state_t                 state;
    bcd_time_t              preset;
    bcd_time_t              cur;
    logic [ALARM_CNT_W-1:0] alarm_cnt;
    logic [ALARM_CNT_W-1:0] alarm_cnt_inc;
    logic                   running_q;
    logic                   alarm_q;

    // Only the highest-priority event acts in a cycle.
    logic ev_clear, ev_ss, ev_tick, ev_set;
    assign ev_clear = bus.CLEAR;
    assign ev_ss    = !bus.CLEAR && bus.START_STOP;
    assign ev_tick  = !bus.CLEAR && !bus.START_STOP && bus.TICK;
    assign ev_set   = !bus.CLEAR && !bus.START_STOP && !bus.TICK;

    logic is_zero, is_one, alarm_done;
    assign is_zero       = (cur == TIME_ZERO);
    assign is_one        = (cur == TIME_ONE);
    assign alarm_cnt_inc = alarm_cnt + 1'b1;
    assign alarm_done    = (alarm_cnt_inc == ALARM_CNT_W'(ALARM_TICKS));

    logic      load, load_preset, inc_min, inc_sec, dec;
    bcd_time_t load_val;

    // Digit control decoded from state and the winning event.
    always_comb begin
        load        = 1'b0;
        load_preset = 1'b0;
        inc_min     = 1'b0;
        inc_sec     = 1'b0;
        dec         = 1'b0;
        case (state)
            StIdle: begin
                if (ev_clear) begin
                    load = 1'b1;
                end else if (ev_set) begin
                    inc_min = bus.SET_MIN;
                    inc_sec = bus.SET_SEC;
                end
            end
            StRun: begin
                if (ev_clear) begin
                    load = 1'b1;
                end else if (ev_tick) begin
                    dec = 1'b1;
                end
            end
            StPause: begin
                if (ev_clear) begin
                    load = 1'b1;
                end
            end
            StAlarm: begin
                if (ev_clear) begin
                    load = 1'b1;
                end else if (ev_ss || (ev_tick && alarm_done)) begin
                    load        = 1'b1;
                    load_preset = 1'b1;
                end
            end
            default: load = 1'b1;
        endcase
    end

    assign load_val = load_preset ? preset : TIME_ZERO;

    // Borrow/carry chains: seconds and minutes increment independently, decrement cascades.
    logic bo_so, bo_st, bo_mo, co_so, co_mo;
    logic unused_flags;
    logic co_st, co_mt, bo_mt;
    assign unused_flags = co_st ^ co_mt ^ bo_mt;

    bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .LOAD     (load),
        .LOAD_VAL (load_val.sec_ones),
        .INC      (inc_sec),
        .DEC      (dec),
        .Q        (cur.sec_ones),
        .BO       (bo_so),
        .CO       (co_so)
    );

    bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .LOAD     (load),
        .LOAD_VAL (load_val.sec_tens),
        .INC      (co_so),
        .DEC      (bo_so),
        .Q        (cur.sec_tens),
        .BO       (bo_st),
        .CO       (co_st)
    );

    bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .LOAD     (load),
        .LOAD_VAL (load_val.min_ones),
        .INC      (inc_min),
        .DEC      (bo_st),
        .Q        (cur.min_ones),
        .BO       (bo_mo),
        .CO       (co_mo)
    );

    bcd_digit #(.MAX(BCD_MAX_TENS)) u_min_tens (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .LOAD     (load),
        .LOAD_VAL (load_val.min_tens),
        .INC      (co_mo),
        .DEC      (bo_mo),
        .Q        (cur.min_tens),
        .BO       (bo_mt),
        .CO       (co_mt)
    );

    // Sequencing FSM with registered RUNNING/ALARM, preset capture and alarm duration count.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= StIdle;
            preset    <= TIME_ZERO;
            alarm_cnt <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (ev_clear) begin
                        preset <= TIME_ZERO;
                    end else if (ev_ss && !is_zero) begin
                        preset    <= cur;
                        state     <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (ev_clear) begin
                        state     <= StIdle;
                        running_q <= 1'b0;
                    end else if (ev_ss) begin
                        state     <= StPause;
                        running_q <= 1'b0;
                    end else if (ev_tick && is_one) begin
                        state     <= StAlarm;
                        alarm_cnt <= '0;
                        running_q <= 1'b0;
                        alarm_q   <= 1'b1;
                    end
                end
                StPause: begin
                    if (ev_clear) begin
                        state <= StIdle;
                    end else if (ev_ss) begin
                        state     <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StAlarm: begin
                    if (ev_clear || ev_ss) begin
                        state   <= StIdle;
                        alarm_q <= 1'b0;
                    end else if (ev_tick) begin
                        alarm_cnt <= alarm_cnt_inc;
                        if (alarm_done) begin
                            state   <= StIdle;
                            alarm_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= StIdle;
                    running_q <= 1'b0;
                    alarm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MIN_TENS = cur.min_tens;
    assign bus.MIN_ONES = cur.min_ones;
    assign bus.SEC_TENS = cur.sec_tens;
    assign bus.SEC_ONES = cur.sec_ones;
    assign bus.RUNNING  = running_q;
    assign bus.ALARM    = alarm_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: integer-seconds reference model feeding a scoreboard.
module tb_timer_ctrl;

    localparam int unsigned ALARM_TICKS = 10;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    timer_ctrl_if bus ();

    timer_ctrl #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [17:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: 0 idle, 1 run, 2 pause, 3 alarm; time in whole seconds.
    int m_state = 0;
    int m_time = 0;
    int m_preset = 0;
    int m_cnt = 0;

    function automatic logic [17:0] observed();
        return {bus.MIN_TENS, bus.MIN_ONES, bus.SEC_TENS, bus.SEC_ONES, bus.RUNNING, bus.ALARM};
    endfunction

    function automatic logic [17:0] model_out();
        int m = m_time / 60;
        int s = m_time % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), m_state == 1, m_state == 3};
    endfunction

    task automatic model_step(input logic rst, clr, ss, tk, smin, ssec);
        int m, s;
        if (rst) begin
            m_state = 0; m_time = 0; m_preset = 0; m_cnt = 0;
        end else if (clr) begin
            if (m_state == 0) m_preset = 0;
            m_state = 0;
            m_time  = 0;
        end else if (ss) begin
            case (m_state)
                0: if (m_time != 0) begin m_preset = m_time; m_state = 1; end
                1: m_state = 2;
                2: m_state = 1;
                default: begin m_state = 0; m_time = m_preset; end
            endcase
        end else if (tk) begin
            if (m_state == 1) begin
                m_time--;
                if (m_time == 0) begin m_state = 3; m_cnt = 0; end
            end else if (m_state == 3) begin
                m_cnt++;
                if (m_cnt == ALARM_TICKS) begin m_state = 0; m_time = m_preset; end
            end
        end else if (m_state == 0) begin
            m = m_time / 60;
            s = m_time % 60;
            if (smin) m = (m + 1) % 60;
            if (ssec) s = (s + 1) % 60;
            m_time = m * 60 + s;
        end
    endtask

    // Scoreboard: compare one expected entry per clock, away from the active edge.
    always @(negedge CLOCK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, 32'(observed()), 32'(e.val));
        end
    end

    task automatic step(input string tag, input logic rst, clr, ss, tk, smin, ssec);
        exp_t e;
        @(negedge CLOCK);
        #1;
        RESET = rst; bus.CLEAR = clr; bus.START_STOP = ss;
        bus.TICK = tk; bus.SET_MIN = smin; bus.SET_SEC = ssec;
        model_step(rst, clr, ss, tk, smin, ssec);
        e.val = model_out();
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0; bus.CLEAR = 1'b0; bus.START_STOP = 1'b0;
        bus.TICK = 1'b0; bus.SET_MIN = 1'b0; bus.SET_SEC = 1'b0;
    endtask

    task automatic steps(input string tag, input int n, input logic clr, ss, tk, smin, ssec);
        for (int i = 0; i < n; i++) step(tag, 1'b0, clr, ss, tk, smin, ssec);
    endtask

    // Direct check against a hand-derived display value.
    task automatic expect_disp(input string tag, input logic [15:0] d, input logic run, alm);
        @(negedge CLOCK);
        #2;
        check_eq(tag, 32'(observed()), 32'({d, run, alm}));
    endtask

    initial begin
        bus.CLEAR = 1'b0; bus.START_STOP = 1'b0; bus.TICK = 1'b0;
        bus.SET_MIN = 1'b0; bus.SET_SEC = 1'b0;

        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_disp("reset_state", 16'h0000, 1'b0, 1'b0);

        steps("set_min", 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        steps("set_sec", 61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_disp("set_0201", 16'h0201, 1'b0, 1'b0);

        steps("clear", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("set_min", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("borrow_0059", 16'h0059, 1'b1, 1'b0);

        steps("clear", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("set_min", 10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("borrow_0959", 16'h0959, 1'b1, 1'b0);

        steps("clear", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("set_sec", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("alarm_on", 16'h0000, 1'b0, 1'b1);
        steps("alarm_tick", 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("alarm_hold", 16'h0000, 1'b0, 1'b1);
        steps("alarm_tick", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("alarm_done", 16'h0002, 1'b0, 1'b0);

        steps("clear", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("set_sec", 30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("pause_tick", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_disp("pause_0030", 16'h0030, 1'b0, 1'b0);
        steps("tick", 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("pause_frozen", 16'h0030, 1'b0, 1'b0);
        steps("resume", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("resume_0029", 16'h0029, 1'b1, 1'b0);

        steps("clear", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        steps("start_zero", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_disp("start_zero", 16'h0000, 1'b0, 1'b0);
        steps("set_min", 60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_disp("min_wrap", 16'h0000, 1'b0, 1'b0);
        steps("set_both", 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_disp("set_both", 16'h0303, 1'b0, 1'b0);
        steps("tick_idle", 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_disp("tick_over_set", 16'h0303, 1'b0, 1'b0);
        steps("clr_over_ss", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_disp("clr_over_ss", 16'h0000, 1'b0, 1'b0);

        steps("set_sec", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("alarm_0001", 16'h0000, 1'b0, 1'b1);
        step("reset_alarm", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("reset_alarm", 16'h0000, 1'b0, 1'b0);

        steps("set_min", 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        steps("set_sec", 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_disp("run_0510", 16'h0510, 1'b1, 1'b0);
        steps("clear_run", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_disp("clear_run", 16'h0000, 1'b0, 1'b0);

        steps("set_sec", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        steps("start", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        steps("tick", 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        steps("stop_alarm", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_disp("stop_alarm", 16'h0003, 1'b0, 1'b0);

        // Random pulse mix, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            step("random", $urandom_range(499) == 0, $urandom_range(79) == 0,
                 $urandom_range(11) == 0, $urandom_range(2) == 0,
                 $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        repeat (3) @(negedge CLOCK);
        #2;
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown-timer controller for the mm:ss display chain. It owns four BCD digit counters: minutes 00–59, seconds 00–59, seconds-tens and minutes-tens modulo 6, ones digits modulo 10.
- Sequences set / run / pause / alarm from debounced single-cycle button pulses and a 1 Hz TICK strobe.
- Sits between the button debouncers / prescaler and the 7-segment decoders; drives the buzzer enable.

Parameters:
- ALARM_TICKS, 10, number of TICK periods ALARM stays asserted before auto-return to IDLE (1..255).

Ports:
- CLOCK  input  1  system clock; all state on rising edge.
- RESET  input  1  synchronous, active-high reset.
- TICK  input  1  1-cycle strobe, once per second.
- START_STOP  input  1  1-cycle debounced pulse.
- CLEAR  input  1  1-cycle debounced pulse.
- SET_MIN  input  1  1-cycle pulse; increment minutes in IDLE.
- SET_SEC  input  1  1-cycle pulse; increment seconds in IDLE.
- MIN_TENS  output  4  BCD 0..5.
- MIN_ONES  output  4  BCD 0..9.
- SEC_TENS  output  4  BCD 0..5.
- SEC_ONES  output  4  BCD 0..9.
- RUNNING  output  1  high in RUN.
- ALARM  output  1  high in ALARM (buzzer enable).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all digits 0, saved preset 00:00, alarm counter 0, RUNNING=0, ALARM=0.
- Outputs are registered; all effects are visible the cycle after the input pulse.
- Input priority per cycle: CLEAR > START_STOP > TICK > SET_MIN/SET_SEC. Only the highest-priority active event acts; the rest are dropped, not queued.
- If SET_MIN and SET_SEC are both high in IDLE, both increment.
- IDLE:
  - SET_MIN: minutes +1, wrapping 59->00.
  - SET_SEC: seconds +1, wrapping 59->00, no carry into minutes.
  - START_STOP with time != 00:00: copy digits to the preset register, go to RUN.
  - START_STOP with 00:00: ignored, stay in IDLE.
  - CLEAR: digits and preset go to 00:00.
  - TICK: ignored.
- RUN:
  - TICK: decrement mm:ss by 1 s.
    - sec_ones 0->9 with borrow to sec_tens.
    - sec_tens 0->5 with borrow to min_ones.
    - min_ones 0->9 with borrow to min_tens.
  - TICK while display is 00:01: digits become 00:00 and state goes to ALARM on the same edge.
  - START_STOP: go to PAUSE; a coincident TICK is dropped.
  - CLEAR: go to IDLE with digits 00:00; preset is kept.
  - SET_*: ignored.
- PAUSE:
  - Digits frozen.
  - START_STOP: go to RUN.
  - CLEAR: go to IDLE with 00:00.
  - TICK and SET_*: ignored.
- ALARM:
  - ALARM=1, digits 00:00.
  - Alarm counter clears on entry and increments on each TICK.
  - When the counter reaches ALARM_TICKS (on that TICK edge), go to IDLE and restore digits from the preset.
  - START_STOP: immediately IDLE with preset restored.
  - CLEAR: IDLE with 00:00.
- Digits never leave their legal BCD range. Illegal state encodings recover to IDLE with digits 00:00.
- RESET asserted mid-RUN or mid-ALARM overrides everything on that edge.

Decomposition:
- Package timer_pkg:
  - state enum IDLE/RUN/PAUSE/ALARM (2 bits);
  - BCD constants for digit maxima (9, 5);
  - ALARM counter width localparam (8).
- Sub-module bcd_digit, one instance per digit:
  - parameter MAX (9 or 5);
  - ports CLOCK, RESET, LOAD, LOAD_VAL, INC, DEC, Q, and combinational BO (DEC while Q==0) / CO (INC while Q==MAX);
  - wrap on both directions.
- The controller cascades DEC through the BO outputs and gates INC per minutes/seconds pair.

Test Plan:
- Reset, then SET_MIN x2 and SET_SEC x61 -> display 02:01; RUNNING=0.
- Set 01:00, START_STOP, 1 TICK -> 00:59 (borrow through both seconds digits); RUNNING=1.
- Set 00:02, START_STOP, 2 TICKs -> 00:00 with ALARM=1 the cycle after the 2nd TICK. After 10 more TICKs -> ALARM=0, display back to 00:02, state IDLE.
- In RUN at 00:30, START_STOP and TICK in the same cycle -> PAUSE, display stays 00:30. 3 TICKs -> still 00:30. START_STOP, TICK -> 00:29.
- START_STOP at 00:00 in IDLE -> no state change. SET_MIN x60 -> minutes wrap to 00.
- RESET pulsed in ALARM, and CLEAR in RUN at 05:10 -> IDLE 00:00, ALARM=0.
